// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, runs req/ack fetches to imem,
// hands instructions to decode, and redirects on taken jumps/branches from execute.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        dec_ready,
  input  logic        br_valid,
  input  logic [2:0]  br_opcode,
  input  logic        br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_addr,
  input  logic [31:0] br_jreg,
  output logic [31:0] pc,
  output logic        redirect
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_reg;
  logic [31:0] fetch_addr_reg;
  logic [31:0] redirect_pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        inst_valid_reg;
  logic        redirect_reg;

  logic        taken_raw;
  logic        taken;
  logic [31:0] target;

  // Opcodes 011 and anything unlisted fall through as not-taken.
  always_comb begin
    taken_raw = 1'b0;
    target    = 32'h0;
    case (br_opcode)
      3'b100: begin
        taken_raw = 1'b1;
        target    = {br_pc[31:18], br_addr[15:0], 2'b00};
      end
      3'b101: begin
        taken_raw = 1'b1;
        target    = br_jreg;
      end
      3'b110, 3'b111: begin
        taken_raw = br_cond;
        target    = br_pc + {br_addr[29:0], 2'b00};
      end
      default: begin
        taken_raw = 1'b0;
        target    = 32'h0;
      end
    endcase
    taken = br_valid & taken_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FETCH;
      fetch_addr_reg  <= RESET_PC;
      redirect_pc_reg <= 32'h0;
      inst_reg        <= 32'h0;
      inst_pc_reg     <= 32'h0;
      inst_valid_reg  <= 1'b0;
      redirect_reg    <= 1'b0;
    end else begin
      redirect_reg <= taken;
      case (state_reg)
        FETCH: begin
          if (taken) begin
            // An unacked request cannot be abandoned; park the target until it drains.
            if (imem_ack) begin
              fetch_addr_reg <= target;
            end else begin
              redirect_pc_reg <= target;
              state_reg       <= DRAIN;
            end
          end else if (imem_ack) begin
            inst_reg       <= imem_data;
            inst_pc_reg    <= fetch_addr_reg;
            inst_valid_reg <= 1'b1;
            fetch_addr_reg <= fetch_addr_reg + 32'd4;
            state_reg      <= HOLD;
          end
        end
        HOLD: begin
          if (taken) begin
            fetch_addr_reg <= target;
            inst_valid_reg <= 1'b0;
            state_reg      <= FETCH;
          end else if (dec_ready) begin
            inst_valid_reg <= 1'b0;
            state_reg      <= FETCH;
          end
        end
        DRAIN: begin
          if (taken) begin
            redirect_pc_reg <= target;
          end
          if (imem_ack) begin
            fetch_addr_reg <= taken ? target : redirect_pc_reg;
            state_reg      <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign imem_req   = (state_reg == FETCH) || (state_reg == DRAIN);
  assign imem_addr  = fetch_addr_reg;
  assign pc         = fetch_addr_reg;
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_valid = inst_valid_reg;
  assign redirect   = redirect_reg;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch sequencer sitting between the instruction memory and decode in the CPU datapath. Owns the fetch PC and sequences each fetch as a req/ack transaction. Hands fetched instructions to decode with a valid/ready handshake, predicts PC+4, and redirects on taken control transfers reported by execute. Uses the datapath's 3-bit branch opcode encoding so execute drives it directly.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; held high until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req high
- imem_ack  in  1  memory returns imem_data this cycle
- imem_data  in  32  instruction word, sampled when imem_req & imem_ack
- inst  out  32  fetched instruction to decode
- inst_pc  out  32  address of inst
- inst_valid  out  1  inst/inst_pc valid
- dec_ready  in  1  decode accepts when inst_valid & dec_ready
- br_valid  in  1  execute reports a control instruction this cycle
- br_opcode  in  3  011 seq, 100 jump, 101 jump-register, 110/111 conditional branch
- br_cond  in  1  condition result for 110/111
- br_pc  in  32  PC of the reporting control instruction
- br_addr  in  32  immediate: jump index / branch word offset
- br_jreg  in  32  register target for 101
- pc  out  32  current fetch PC (equals imem_addr)
- redirect  out  1  one-cycle pulse: a redirect was accepted last cycle

## Operation
- States: FETCH, HOLD, DRAIN. Registers: fetch_addr, redirect_pc, inst, inst_pc, inst_valid, redirect.
- imem_req = 1 in FETCH and DRAIN, else 0. imem_addr = pc = fetch_addr.
- Taken target (taken = br_valid & computed below):
  - 100: {br_pc[31:18], br_addr[15:0], 2'b00}, always taken.
  - 101: br_jreg, always taken.
  - 110/111: br_pc + {br_addr[29:0], 2'b00} if br_cond; not taken otherwise.
  - 011 and all other codes: not taken, no effect.
  - Adds are 32-bit modulo 2^32; wrap-around ignored.
- FETCH, no taken: on imem_ack, inst<=imem_data, inst_pc<=fetch_addr, inst_valid<=1, fetch_addr<=fetch_addr+4, go HOLD; else stay.
- FETCH, taken & imem_ack: discard data, fetch_addr<=target, stay FETCH.
- FETCH, taken & !imem_ack: redirect_pc<=target, go DRAIN (request not abandoned).
- DRAIN: taken overwrites redirect_pc (latest wins). On imem_ack discard data; fetch_addr<=(taken ? target : redirect_pc), go FETCH.
- HOLD: inst_valid=1, inputs to inst/inst_pc frozen. taken: fetch_addr<=target, inst_valid<=0, go FETCH. Else dec_ready: inst_valid<=0, go FETCH. Else stay.
- Taken in the same cycle as inst_valid & dec_ready: transfer counts as accepted; squashing is execute's job.
- redirect<=taken every cycle in all states.

## Timing
- Reset (rst high at posedge): state FETCH, fetch_addr=RESET_PC, redirect_pc=0, inst=0, inst_pc=0, inst_valid=0, redirect=0. imem_req is 1 in the first cycle after rst falls.
- rst mid-transaction aborts: any in-flight ack afterwards is treated as a response to the new RESET_PC request; memory must drop its pending request on rst.
- Fetch latency: inst_valid rises the cycle after imem_ack.
- Peak throughput: one instruction per 2 cycles (FETCH with ack, HOLD with ready).
- Redirect latency: new address on imem_addr the cycle after taken, except from FETCH without ack (waits for the outstanding ack via DRAIN).
- redirect pulse is exactly 1 cycle after the taken cycle, one pulse per taken cycle.

## Test plan
- Reset, RESET_PC=0x100, ack each request after 1 cycle, dec_ready=1 -> inst_pc sequence 0x100, 0x104, 0x108; inst_valid every other cycle.
- HOLD backpressure: dec_ready=0 for 5 cycles -> inst/inst_pc/inst_valid stable, imem_req=0; dec_ready=1 -> next fetch at inst_pc+4.
- In HOLD, br 100 with br_pc=0x0004_0010, br_addr=0x0020 -> imem_addr=0x0004_0080 next cycle, redirect pulses once; br 101 with br_jreg=0x200 -> 0x200.
- br 110, br_pc=0x100, br_addr=3: br_cond=1 -> target 0x10C; br_cond=0 -> no redirect, fetch continues sequentially.
- Taken (target 0x300) during FETCH with ack held off 3 cycles -> imem_addr stays old until ack, data discarded, inst_valid stays 0, then imem_addr=0x300; second taken to 0x400 in DRAIN -> 0x400 wins.
- Taken coincident with imem_ack in FETCH -> data discarded, imem_addr=target next cycle, no inst_valid; rst asserted in DRAIN -> all outputs at reset values next cycle.
